// File: rtl/rns_add_sequencer.sv
// Steps one shared single-modulus residue adder across all RNS channels of an
// operand pair, collecting the per-channel sums into one packed result.
module rns_add_sequencer #(
    parameter int                         NUM_MOD = 3,
    parameter int                         RES_W   = 3,
    parameter logic [NUM_MOD*RES_W-1:0]   MODULI  = {3'd7, 3'd5, 3'd3},
    parameter int                         ADD_LAT = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_MOD*RES_W-1:0]   in_a,
    input  logic [NUM_MOD*RES_W-1:0]   in_b,
    output logic [RES_W-1:0]           add_a,
    output logic [RES_W-1:0]           add_b,
    output logic [RES_W-1:0]           add_mod,
    input  logic [RES_W-1:0]           add_sum,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_MOD*RES_W-1:0]   out_sum,
    output logic [NUM_MOD-1:0]         out_err,
    output logic                       busy,
    output logic [7:0]                 done_cnt
);

    localparam int IDX_W = (NUM_MOD > 1) ? $clog2(NUM_MOD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOD - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (NUM_MOD < 2 || NUM_MOD > 8) begin : g_bad_num_mod
            $error("rns_add_sequencer: NUM_MOD must be 2..8");
        end
        if (ADD_LAT != 0 && ADD_LAT != 1) begin : g_bad_add_lat
            $error("rns_add_sequencer: ADD_LAT must be 0 or 1");
        end
        for (genvar g = 0; g < NUM_MOD; g++) begin : g_mod_chk
            if (MODULI[g*RES_W +: RES_W] < RES_W'(2)) begin : g_bad_mod
                $error("rns_add_sequencer: every modulus must be at least 2");
            end
        end
    endgenerate

    logic [1:0]         state;
    logic [IDX_W-1:0]   idx;
    logic               phase;
    logic [RES_W-1:0]   a_arr   [NUM_MOD];
    logic [RES_W-1:0]   b_arr   [NUM_MOD];
    logic [RES_W-1:0]   sum_arr [NUM_MOD];
    logic [RES_W-1:0]   mod_arr [NUM_MOD];
    logic [NUM_MOD-1:0] err_reg;
    logic               capture;

    always_comb begin
        for (int unsigned i = 0; i < NUM_MOD; i++) begin
            mod_arr[i] = MODULI[i*RES_W +: RES_W];
        end
    end

    // With a registered adder the sum for the presented channel is only
    // valid in the second cycle, so capture waits for phase 1.
    always_comb begin
        capture = (ADD_LAT == 0) ? 1'b1 : phase;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            phase     <= 1'b0;
            out_valid <= 1'b0;
            done_cnt  <= '0;
            err_reg   <= '0;
            for (int unsigned i = 0; i < NUM_MOD; i++) begin
                a_arr[i]   <= '0;
                b_arr[i]   <= '0;
                sum_arr[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int unsigned i = 0; i < NUM_MOD; i++) begin
                            a_arr[i]   <= in_a[i*RES_W +: RES_W];
                            b_arr[i]   <= in_b[i*RES_W +: RES_W];
                            err_reg[i] <= (in_a[i*RES_W +: RES_W] >= mod_arr[i]) |
                                          (in_b[i*RES_W +: RES_W] >= mod_arr[i]);
                        end
                        idx   <= '0;
                        phase <= 1'b0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (capture) begin
                        sum_arr[idx] <= add_sum;
                        phase        <= 1'b0;
                        if (idx == LAST_IDX) begin
                            idx       <= '0;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        phase <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        done_cnt  <= done_cnt + 8'd1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        in_ready = (state == S_IDLE);
        busy     = (state != S_IDLE);
        out_err  = err_reg;
        add_a    = '0;
        add_b    = '0;
        add_mod  = '0;
        if (state == S_RUN) begin
            add_a   = a_arr[idx];
            add_b   = b_arr[idx];
            add_mod = mod_arr[idx];
        end
        out_sum = '0;
        for (int unsigned i = 0; i < NUM_MOD; i++) begin
            out_sum[i*RES_W +: RES_W] = sum_arr[i];
        end
    end

endmodule

// File: tb/tb_rns_add_sequencer.sv
// Self-checking bench: two sequencer instances (combinational and registered
// adder) with behavioural adders and a plain-arithmetic RNS reference.
module tb_rns_add_sequencer;

    localparam int NM = 3;
    localparam int RW = 3;
    localparam int MODS [NM] = '{3, 5, 7};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sel = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [NM*RW-1:0] in_a = '0;
    logic [NM*RW-1:0] in_b = '0;

    logic in_valid0, in_valid1;
    logic in_ready0, in_ready1;
    logic [RW-1:0] add_a0, add_b0, add_mod0, add_sum0;
    logic [RW-1:0] add_a1, add_b1, add_mod1, add_sum1;
    logic [RW-1:0] r_a1, r_b1, r_m1;
    logic out_valid0, out_valid1;
    logic [NM*RW-1:0] out_sum0, out_sum1;
    logic [NM-1:0] out_err0, out_err1;
    logic busy0, busy1;
    logic [7:0] done_cnt0, done_cnt1;

    logic v_in_ready, v_out_valid, v_busy;
    logic [RW-1:0] v_add_a, v_add_b, v_add_mod;
    logic [NM*RW-1:0] v_out_sum;
    logic [NM-1:0] v_out_err;
    logic [7:0] v_done_cnt;

    int n_tests = 0;
    int n_fail = 0;
    logic [7:0] model_done [2];

    always #5 clk = ~clk;

    assign in_valid0 = in_valid & ~sel;
    assign in_valid1 = in_valid & sel;

    rns_add_sequencer #(.NUM_MOD(NM), .RES_W(RW), .MODULI({3'd7, 3'd5, 3'd3}), .ADD_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .add_a(add_a0), .add_b(add_b0), .add_mod(add_mod0),
        .add_sum(add_sum0), .out_valid(out_valid0), .out_ready(out_ready),
        .out_sum(out_sum0), .out_err(out_err0), .busy(busy0), .done_cnt(done_cnt0)
    );

    rns_add_sequencer #(.NUM_MOD(NM), .RES_W(RW), .MODULI({3'd7, 3'd5, 3'd3}), .ADD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .add_a(add_a1), .add_b(add_b1), .add_mod(add_mod1),
        .add_sum(add_sum1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_sum(out_sum1), .out_err(out_err1), .busy(busy1), .done_cnt(done_cnt1)
    );

    // External adders: one combinational, one that registers its inputs.
    always_comb begin
        add_sum0 = (add_mod0 == '0) ? '0 : RW'((int'(add_a0) + int'(add_b0)) % int'(add_mod0));
        add_sum1 = (r_m1 == '0) ? '0 : RW'((int'(r_a1) + int'(r_b1)) % int'(r_m1));
    end

    always_ff @(posedge clk) begin
        r_a1 <= add_a1;
        r_b1 <= add_b1;
        r_m1 <= add_mod1;
    end

    assign v_in_ready  = sel ? in_ready1  : in_ready0;
    assign v_out_valid = sel ? out_valid1 : out_valid0;
    assign v_busy      = sel ? busy1      : busy0;
    assign v_add_a     = sel ? add_a1     : add_a0;
    assign v_add_b     = sel ? add_b1     : add_b0;
    assign v_add_mod   = sel ? add_mod1   : add_mod0;
    assign v_out_sum   = sel ? out_sum1   : out_sum0;
    assign v_out_err   = sel ? out_err1   : out_err0;
    assign v_done_cnt  = sel ? done_cnt1  : done_cnt0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", tag, got, exp, $time, sel);
        end
    endtask

    function automatic logic [NM*RW-1:0] ref_sum(input logic [NM*RW-1:0] a, input logic [NM*RW-1:0] b);
        logic [NM*RW-1:0] r;
        r = '0;
        for (int i = 0; i < NM; i++) begin
            r[i*RW +: RW] = RW'((int'(a[i*RW +: RW]) + int'(b[i*RW +: RW])) % MODS[i]);
        end
        return r;
    endfunction

    function automatic logic [NM-1:0] ref_err(input logic [NM*RW-1:0] a, input logic [NM*RW-1:0] b);
        logic [NM-1:0] e;
        for (int i = 0; i < NM; i++) begin
            e[i] = (int'(a[i*RW +: RW]) >= MODS[i]) || (int'(b[i*RW +: RW]) >= MODS[i]);
        end
        return e;
    endfunction

    // Called at #1 after a rising edge; returns at #1 after a rising edge.
    task automatic run_txn(input logic [NM*RW-1:0] a, input logic [NM*RW-1:0] b, input int stall);
        int lat;
        int steps;
        int waitc;
        int ch;
        logic [NM*RW-1:0] exp_sum;
        logic [NM-1:0] exp_err;
        steps = sel ? 2 : 1;
        lat = NM * steps;
        exp_sum = ref_sum(a, b);
        exp_err = ref_err(a, b);
        waitc = 0;
        while (!v_in_ready && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        check("idle_in_ready", 32'(v_in_ready), 32'd1);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = NM*RW'($urandom);
        in_b = NM*RW'($urandom);
        for (int c = 0; c < lat; c++) begin
            ch = c / steps;
            check("run_in_ready", 32'(v_in_ready), 32'd0);
            check("run_busy", 32'(v_busy), 32'd1);
            check("early_out_valid", 32'(v_out_valid), 32'd0);
            check("add_mod", 32'(v_add_mod), 32'(MODS[ch]));
            check("add_a", 32'(v_add_a), 32'(a[ch*RW +: RW]));
            check("add_b", 32'(v_add_b), 32'(b[ch*RW +: RW]));
            @(posedge clk); #1;
        end
        check("out_valid", 32'(v_out_valid), 32'd1);
        check("out_sum", 32'(v_out_sum), 32'(exp_sum));
        check("out_err", 32'(v_out_err), 32'(exp_err));
        check("done_busy", 32'(v_busy), 32'd1);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(v_out_valid), 32'd1);
            check("bp_out_sum", 32'(v_out_sum), 32'(exp_sum));
            check("bp_out_err", 32'(v_out_err), 32'(exp_err));
            check("bp_in_ready", 32'(v_in_ready), 32'd0);
            check("bp_done_cnt", 32'(v_done_cnt), 32'(model_done[sel]));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        model_done[sel] = model_done[sel] + 8'd1;
        check("post_out_valid", 32'(v_out_valid), 32'd0);
        check("post_in_ready", 32'(v_in_ready), 32'd1);
        check("post_busy", 32'(v_busy), 32'd0);
        check("done_cnt", 32'(v_done_cnt), 32'(model_done[sel]));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        model_done[0] = 8'd0;
        model_done[1] = 8'd0;
        @(posedge clk); #1;
    endtask

    task automatic wrap_test();
        logic [2*NM*RW-1:0] q [$];
        logic [2*NM*RW-1:0] ent;
        int acc;
        int outs;
        int cyc;
        int last_acc;
        acc = 0;
        outs = 0;
        cyc = 0;
        last_acc = -1;
        out_ready = 1'b1;
        while (outs < 256 && cyc < 3000) begin
            in_a = NM*RW'($urandom);
            in_b = NM*RW'($urandom);
            in_valid = (acc < 256);
            @(negedge clk);
            if (in_valid && v_in_ready) begin
                q.push_back({in_a, in_b});
                if (last_acc >= 0) check("accept_gap", 32'(cyc - last_acc), 32'(NM + 2));
                last_acc = cyc;
                acc++;
            end
            if (v_out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out", 32'd1, 32'd0);
                end else begin
                    ent = q.pop_front();
                    check("wrap_out_sum", 32'(v_out_sum), 32'(ref_sum(ent[2*NM*RW-1:NM*RW], ent[NM*RW-1:0])));
                    check("wrap_out_err", 32'(v_out_err), 32'(ref_err(ent[2*NM*RW-1:NM*RW], ent[NM*RW-1:0])));
                end
                outs++;
                model_done[sel] = model_done[sel] + 8'd1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("wrap_outs", 32'(outs), 32'd256);
        check("wrap_accepts", 32'(acc), 32'd256);
        check("wrap_done_cnt", 32'(v_done_cnt), 32'(model_done[sel]));
        check("wrap_done_zero", 32'(v_done_cnt), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_done[0] = 8'd0;
        model_done[1] = 8'd0;
        #2;
        check("rst_out_valid", 32'(v_out_valid), 32'd0);
        check("rst_busy", 32'(v_busy), 32'd0);
        check("rst_out_sum", 32'(v_out_sum), 32'd0);
        check("rst_out_err", 32'(v_out_err), 32'd0);
        check("rst_done_cnt", 32'(v_done_cnt), 32'd0);
        check("rst_add_a", 32'(v_add_a), 32'd0);
        check("rst_add_b", 32'(v_add_b), 32'd0);
        check("rst_add_mod", 32'(v_add_mod), 32'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(v_in_ready), 32'd1);

        // Directed: basic, backpressure, range error on the combinational adder.
        run_txn({3'd6, 3'd4, 3'd2}, {3'd5, 3'd3, 3'd2}, 0);
        run_txn({3'd6, 3'd4, 3'd2}, {3'd5, 3'd3, 3'd2}, 5);
        run_txn({3'd0, 3'd0, 3'd3}, {3'd0, 3'd0, 3'd0}, 1);

        for (int n = 0; n < 40; n++) begin
            run_txn(NM*RW'($urandom), NM*RW'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset after the channel-1 capture abandons the transaction.
        in_a = {3'd6, 3'd4, 3'd2};
        in_b = {3'd5, 3'd3, 3'd2};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(v_out_valid), 32'd0);
        check("midrst_busy", 32'(v_busy), 32'd0);
        check("midrst_out_sum", 32'(v_out_sum), 32'd0);
        check("midrst_done_cnt", 32'(v_done_cnt), 32'd0);
        #2;
        rst_n = 1'b1;
        model_done[0] = 8'd0;
        model_done[1] = 8'd0;
        @(posedge clk); #1;
        run_txn({3'd1, 3'd1, 3'd1}, {3'd1, 3'd1, 3'd1}, 0);

        // Registered adder instance.
        sel = 1'b1;
        #1;
        run_txn({3'd6, 3'd4, 3'd2}, {3'd5, 3'd3, 3'd2}, 0);
        run_txn({3'd0, 3'd0, 3'd3}, {3'd0, 3'd0, 3'd0}, 2);
        for (int n = 0; n < 15; n++) begin
            run_txn(NM*RW'($urandom), NM*RW'($urandom), int'($urandom_range(0, 3)));
        end

        // Back to the combinational instance for the 256-transaction wrap.
        sel = 1'b0;
        do_reset();
        wrap_test();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rns_add_sequencer.md
Name: rns_add_sequencer

Overview:
Time-multiplexes one shared single-modulus residue adder across all channels of an RNS operand pair. It accepts two packed residue vectors over a valid/ready handshake and steps the adder through channel 0..NUM_MOD-1, feeding each channel's residues and modulus. It collects the per-channel sums and presents the packed result over a second valid/ready handshake. It sits between the RNS operand source and the downstream RNS consumer; the adder itself is external and is driven through the add_* ports.

Parameters:
NUM_MOD, 3, number of RNS channels (2..8).
RES_W, 3, residue and modulus width per channel.
MODULI, {3'd7,3'd5,3'd3}, packed moduli with channel i at bits [i*RES_W +: RES_W]. Each modulus is 2..7. Modulus 0 or 1 is an elaboration error.
ADD_LAT, 0, adder latency in cycles. 0 means combinational; 1 means the adder registers its inputs. Any other value is an elaboration error.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands
in_a  in  NUM_MOD*RES_W  packed residues of operand A
in_b  in  NUM_MOD*RES_W  packed residues of operand B
add_a  out  RES_W  residue A to shared adder
add_b  out  RES_W  residue B to shared adder
add_mod  out  RES_W  modulus to shared adder
add_sum  in  RES_W  (add_a+add_b) mod add_mod from shared adder
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_sum  out  NUM_MOD*RES_W  packed modular sums
out_err  out  NUM_MOD  per-channel flag: an input residue was >= its modulus
busy  out  1  high in RUN or DONE
done_cnt  out  8  completed transactions, wraps 255->0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, idx=0, phase=0.
  - in_ready=1 after release; out_valid=0; out_sum=0; out_err=0; busy=0; done_cnt=0.
  - add_a, add_b and add_mod are 0.
  - Reset mid-RUN or mid-DONE abandons the transaction. No output is produced for it.
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready is high at a rising edge: register in_a and in_b, and compute out_err[i] = (a_i>=m_i)|(b_i>=m_i).
  - Then idx=0, phase=0, and the state goes to RUN.
- RUN:
  - in_ready=0.
  - add_a, add_b and add_mod come from registered channel idx, driven directly from registers (no combinational path from in_*).
  - ADD_LAT=0: each cycle, capture add_sum into sum[idx] and increment idx.
  - ADD_LAT=1: phase 0 presents the inputs; phase 1 captures add_sum into sum[idx] and increments idx. Inputs stay stable across both phases.
  - After capturing channel NUM_MOD-1: set out_valid=1, go to DONE, and set idx=0.
- DONE:
  - out_sum and out_err are held stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready at an edge: out_valid=0, done_cnt+=1, state goes to IDLE.
  - No same-cycle re-accept: in_ready rises the cycle after the handshake.
- Latency: accept at edge k; out_valid is first high after edge k+NUM_MOD*(1+ADD_LAT). Minimum issue interval is NUM_MOD*(1+ADD_LAT)+2 cycles.
- Out-of-range residues: the transaction still runs. out_sum holds whatever the adder returns. The error is reported only via out_err.
- Arithmetic: all modular math is performed by the external adder. The block does no arithmetic except the range compare and idx/phase/done_cnt counting.
- in_valid while busy is ignored; operands are not captured. in_* may change freely outside the IDLE handshake.

Test Plan:
- Basic run (ADD_LAT=0, default MODULI):
  - Stimulus: in_a={3'd6,3'd4,3'd2}, in_b={3'd5,3'd3,3'd2}, accepted at edge k.
  - Response: add_mod sequence 3,5,7; out_valid after edge k+3; out_sum={3'd4,3'd2,3'd1}; out_err=0; done_cnt=1.
- Backpressure:
  - Stimulus: same operands; out_ready held 0 for 5 cycles, then 1.
  - Response: out_sum is stable the whole time; in_ready=0 until the cycle after the handshake; done_cnt increments once.
- ADD_LAT=1:
  - Stimulus: same operands.
  - Response: each add_* triple is held 2 cycles; out_valid after edge k+6; out_sum={3'd4,3'd2,3'd1}.
- Range error:
  - Stimulus: in_a channel0=3'd3 (modulus 3), all other residues 0.
  - Response: out_err=3'b001; transaction completes normally.
- Reset mid-run:
  - Stimulus: rst_n=0 asynchronously after the channel-1 capture.
  - Response: out_valid, busy, out_sum and done_cnt are 0 immediately. After release, a new transaction {1,1,1}+{1,1,1} yields {3'd2,3'd2,3'd2}.
- Busy ignore and wrap:
  - Stimulus: in_valid held high continuously with out_ready=1 for 256 transactions.
  - Response: exactly one capture per IDLE visit; done_cnt wraps to 0.
